// File: rtl/scr1_pipe_ialu_mdu.sv
// Iterative RV multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Latency: result valid XLEN+2 cycles after accept; divide-by-zero/overflow shortcut gives 1 cycle.
// Backpressure: holds the result in DONE until res_ack_i and accepts nothing meanwhile; kill_i aborts.
module scr1_pipe_ialu_mdu #(
    parameter int XLEN             = 32,
    parameter bit FAST_DIV_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_vd_i,
    output logic            cmd_rdy_o,
    input  logic [2:0]      cmd_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic            kill_i,
    output logic            res_vd_o,
    output logic [XLEN-1:0] res_o,
    input  logic            res_ack_i
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, CORR, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      cmd_q;
    logic [XLEN-1:0] hi, lo, b, res_q;
    logic            neg_res, neg_rem;

    // Operand decode at accept time
    logic            is_div, op1_sgn, op2_sgn, s1, s2, div_zero, div_ovf;
    logic [XLEN-1:0] mag1, mag2, fast_res;

    always_comb begin
        is_div   = cmd_i[2];
        op1_sgn  = (cmd_i == 3'd1) || (cmd_i == 3'd2) || (cmd_i == 3'd4) || (cmd_i == 3'd6);
        op2_sgn  = (cmd_i == 3'd1) || (cmd_i == 3'd4) || (cmd_i == 3'd6);
        s1       = op1_sgn & op1_i[XLEN-1];
        s2       = op2_sgn & op2_i[XLEN-1];
        mag1     = s1 ? -op1_i : op1_i;
        mag2     = s2 ? -op2_i : op2_i;
        div_zero = is_div && (op2_i == '0);
        div_ovf  = is_div && !cmd_i[0] && (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
        fast_res = '0;
        if (div_zero)
            fast_res = cmd_i[1] ? op1_i : '1;
        else if (div_ovf)
            fast_res = cmd_i[1] ? '0 : op1_i;
    end

    // One radix-2 step; hi:lo is the product or remainder:quotient pair
    logic [XLEN:0]   sum, shifted, diff;
    logic [XLEN-1:0] hi_n, lo_n;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, b};
        hi_n    = '0;
        lo_n    = '0;
        if (cmd_q[2]) begin
            if (!diff[XLEN]) begin
                hi_n = diff[XLEN-1:0];
                lo_n = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_n = shifted[XLEN-1:0];
                lo_n = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_n = sum[XLEN:1];
            lo_n = {sum[0], lo[XLEN-1:1]};
        end
    end

    // Sign correction and result selection
    logic [2*XLEN-1:0] prod_c;
    logic [XLEN-1:0]   quo_c, rem_c, corr_res;

    always_comb begin
        prod_c = neg_res ? -{hi, lo} : {hi, lo};
        quo_c  = neg_res ? -lo : lo;
        rem_c  = neg_rem ? -hi : hi;
        case (cmd_q)
            3'd0:                corr_res = prod_c[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    corr_res = prod_c[2*XLEN-1:XLEN];
            3'd4, 3'd5:          corr_res = quo_c;
            default:             corr_res = rem_c;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            cmd_q   <= '0;
            hi      <= '0;
            lo      <= '0;
            b       <= '0;
            res_q   <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
        end else if (kill_i) begin
            state <= IDLE;
            cnt   <= '0;
            res_q <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_vd_i) begin
                    cmd_q <= cmd_i;
                    // A zero divisor leaves the all-ones quotient unsigned
                    neg_res <= (s1 ^ s2) && !div_zero;
                    neg_rem <= s1;
                    if (FAST_DIV_SPECIAL && (div_zero || div_ovf)) begin
                        res_q <= fast_res;
                        state <= DONE;
                    end else begin
                        cnt   <= CW'(XLEN);
                        hi    <= '0;
                        lo    <= is_div ? mag1 : mag2;
                        b     <= is_div ? mag2 : mag1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    hi  <= hi_n;
                    lo  <= lo_n;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= CORR;
                end
                CORR: begin
                    res_q <= corr_res;
                    state <= DONE;
                end
                DONE: if (res_ack_i) begin
                    res_q <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cmd_rdy_o = (state == IDLE);
    assign res_vd_o  = (state == DONE);
    assign res_o     = res_vd_o ? res_q : '0;
endmodule

// File: tb/tb_scr1_pipe_ialu_mdu.sv
// Randomized and directed checks of the iterative multiply/divide unit against a 64-bit arithmetic model.
module tb_scr1_pipe_ialu_mdu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_vd = 1'b0;
    logic        cmd_rdy;
    logic [2:0]  cmd = '0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        kill = 1'b0;
    logic        res_vd;
    logic [31:0] res;
    logic        res_ack = 1'b0;

    int checks = 0;
    int passed = 0;

    scr1_pipe_ialu_mdu #(.XLEN(32), .FAST_DIV_SPECIAL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_vd_i(cmd_vd), .cmd_rdy_o(cmd_rdy),
        .cmd_i(cmd), .op1_i(op1), .op2_i(op2), .kill_i(kill),
        .res_vd_o(res_vd), .res_o(res), .res_ack_i(res_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
        logic [63:0]        ea, ed, p;
        logic signed [31:0] sa, sd;
        logic               ovf;
        sa  = a;
        sd  = d;
        ovf = (a == 32'h8000_0000) && (d == 32'hFFFF_FFFF);
        ea  = (c == 3'd1 || c == 3'd2) ? {{32{a[31]}}, a} : {32'h0, a};
        ed  = (c == 3'd1) ? {{32{d[31]}}, d} : {32'h0, d};
        p   = ea * ed;
        case (c)
            3'd0:    return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4:    return (d == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sd);
            3'd5:    return (d == 0) ? 32'hFFFF_FFFF : a / d;
            3'd6:    return (d == 0) ? a : ovf ? 32'h0 : 32'(sa % sd);
            default: return (d == 0) ? a : a % d;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
        if (c[2] && (d == 0 || (!c[0] && a == 32'h8000_0000 && d == 32'hFFFF_FFFF)))
            return 1;
        return 34;
    endfunction

    // Issue one command, wait (bounded) for the result, capture it and acknowledge
    task automatic run_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] r, output int lat);
        @(negedge clk);
        cmd_vd = 1'b1; cmd = c; op1 = a; op2 = d;
        @(posedge clk);
        @(negedge clk);
        cmd_vd = 1'b0; cmd = 3'($urandom); op1 = $urandom; op2 = $urandom;
        lat = 1;
        while (!res_vd && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        r = res;
        res_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ack = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (cmd_rdy !== 1'b1) $display("FAIL reset_rdy: got %b want 1", cmd_rdy); else passed++;
        checks++; if (res_vd !== 1'b0) $display("FAIL reset_vd: got %b want 0", res_vd); else passed++;
        checks++; if (res !== 32'h0) $display("FAIL reset_res: got %h want 0", res); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        logic [31:0] r;
        int lat;
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, r, lat);
        checks++; if (r !== 32'hFFFF_FFEB) $display("FAIL mul_res: got %h want ffffffeb", r); else passed++;
        checks++; if (lat !== 34) $display("FAIL mul_latency: got %0d want 34", lat); else passed++;
        checks++; if (res_vd !== 1'b0 || res !== 32'h0 || cmd_rdy !== 1'b1)
            $display("FAIL ack_release: vd=%b res=%h rdy=%b want 0/0/1", res_vd, res, cmd_rdy); else passed++;
    endtask

    task automatic test_mulh_variants();
        logic [31:0] r;
        logic [31:0] exp [3] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(3'(i + 1), 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat);
            checks++; if (r !== exp[i]) $display("FAIL mulh_cmd%0d: got %h want %h", i + 1, r, exp[i]); else passed++;
        end
    endtask

    task automatic test_div();
        logic [31:0] r;
        int lat;
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, r, lat);
        checks++; if (r !== 32'hFFFF_FFFD) $display("FAIL div_res: got %h want fffffffd", r); else passed++;
        checks++; if (lat !== 34) $display("FAIL div_latency: got %0d want 34", lat); else passed++;
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, r, lat);
        checks++; if (r !== 32'hFFFF_FFFF) $display("FAIL rem_res: got %h want ffffffff", r); else passed++;
    endtask

    task automatic test_div_special();
        logic [2:0]  c [4] = '{3'd5, 3'd7, 3'd4, 3'd6};
        logic [31:0] a [4] = '{32'd100, 32'd100, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] d [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] e [4] = '{32'hFFFF_FFFF, 32'h64, 32'h8000_0000, 32'h0};
        logic [31:0] r;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(c[i], a[i], d[i], r, lat);
            checks++; if (r !== e[i]) $display("FAIL special%0d_res: got %h want %h", i, r, e[i]); else passed++;
            checks++; if (lat !== 1) $display("FAIL special%0d_latency: got %0d want 1", i, lat); else passed++;
        end
    endtask

    task automatic test_kill();
        logic [31:0] r;
        int lat;
        bit  seen = 0;
        @(negedge clk);
        cmd_vd = 1'b1; cmd = 3'd3; op1 = 32'h1234_5678; op2 = 32'h9ABC_DEF0;
        @(posedge clk);
        @(negedge clk);
        cmd_vd = 1'b0;
        repeat (9) begin
            @(negedge clk);
            if (res_vd) seen = 1;
        end
        kill = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kill = 1'b0;
        checks++; if (cmd_rdy !== 1'b1) $display("FAIL kill_idle: rdy got %b want 1", cmd_rdy); else passed++;
        repeat (40) begin
            @(negedge clk);
            if (res_vd) seen = 1;
        end
        checks++; if (seen !== 1'b0) $display("FAIL kill_no_result: res_vd seen %b want 0", seen); else passed++;
        // Kill wins over a simultaneous accept
        cmd_vd = 1'b1; kill = 1'b1; cmd = 3'd0;
        @(posedge clk);
        @(negedge clk);
        cmd_vd = 1'b0; kill = 1'b0;
        checks++; if (cmd_rdy !== 1'b1) $display("FAIL kill_vs_accept: rdy got %b want 1", cmd_rdy); else passed++;
        run_op(3'd5, 32'd1000, 32'd7, r, lat);
        checks++; if (r !== 32'd142) $display("FAIL after_kill_res: got %h want %h", r, 32'd142); else passed++;
    endtask

    task automatic test_async_reset();
        logic [31:0] r;
        int lat;
        @(negedge clk);
        cmd_vd = 1'b1; cmd = 3'd0; op1 = 32'd5; op2 = 32'd6;
        @(posedge clk);
        @(negedge clk);
        cmd_vd = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (cmd_rdy !== 1'b1 || res_vd !== 1'b0 || res !== 32'h0)
            $display("FAIL async_reset: rdy=%b vd=%b res=%h want 1/0/0", cmd_rdy, res_vd, res); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd2, 32'hFFFF_FFFE, 32'd3, r, lat);
        checks++; if (r !== 32'hFFFF_FFFF) $display("FAIL after_reset_res: got %h want ffffffff", r); else passed++;
    endtask

    task automatic test_hold();
        logic [31:0] exp;
        int lat = 0;
        exp = ref_model(3'd6, 32'hFFFF_F000, 32'd77);
        @(negedge clk);
        cmd_vd = 1'b1; cmd = 3'd6; op1 = 32'hFFFF_F000; op2 = 32'd77;
        @(posedge clk);
        @(negedge clk);
        while (!res_vd && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        for (int i = 0; i < 20; i++) begin
            cmd_vd = 1'b1; cmd = 3'($urandom); op1 = $urandom; op2 = $urandom;
            @(negedge clk);
            checks++; if (res !== exp || res_vd !== 1'b1 || cmd_rdy !== 1'b0)
                $display("FAIL hold%0d: res=%h vd=%b rdy=%b want %h/1/0", i, res, res_vd, cmd_rdy, exp); else passed++;
        end
        res_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ack = 1'b0; cmd_vd = 1'b0;
        checks++; if (res_vd !== 1'b0 || res !== 32'h0 || cmd_rdy !== 1'b1)
            $display("FAIL hold_release: vd=%b res=%h rdy=%b want 0/0/1", res_vd, res, cmd_rdy); else passed++;
    endtask

    task automatic test_random();
        logic [2:0]  c;
        logic [31:0] a, d, r;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            c = 3'($urandom);
            a = $urandom;
            d = $urandom;
            case ($urandom_range(0, 7))
                0: d = 32'h0;
                1: begin a = 32'h8000_0000; d = 32'hFFFF_FFFF; end
                2: d = 32'($urandom_range(1, 15));
                3: d = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(c, a, d, r, lat);
            checks++; if (r !== ref_model(c, a, d))
                $display("FAIL rand%0d_res cmd=%0d a=%h b=%h: got %h want %h", i, c, a, d, r, ref_model(c, a, d)); else passed++;
            checks++; if (lat !== ref_latency(c, a, d))
                $display("FAIL rand%0d_latency cmd=%0d: got %0d want %0d", i, c, lat, ref_latency(c, a, d)); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh_variants();
        test_div();
        test_div_special();
        test_kill();
        test_async_reset();
        test_hold();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
